i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- I2S serial-audio receiver; sits directly upstream of the distortion stage.
- Deserialises the codec ADC stream (BCLK, LRCLK, SDATA) into parallel signed left/right samples in the system clock domain.
- Issues a one-cycle frame strobe when a stereo pair is complete; the pedal datapath registers `in` on that strobe.
- Codec clocks are treated as asynchronous data inputs, oversampled by clk; no second clock domain.

Parameters:
- WIDTH, 16, sample width in bits. Must be 8..32. Two's complement, MSB first on the wire.

Ports:
- clk  input  1  system clock; must be >= 8x bclk frequency
- reset  input  1  asynchronous, active-low reset
- enable  input  1  high = receive; low = idle, outputs hold
- bclk  input  1  codec bit clock (async)
- lrclk  input  1  codec word select (async); 0 = left, 1 = right
- sdata  input  1  codec serial data (async)
- left_out  output  WIDTH  last complete left sample
- right_out  output  WIDTH  last complete right sample
- frame_valid  output  1  one-clk pulse; left_out/right_out updated this cycle
- sync_err  output  1  sticky short-slot/framing error flag

Behaviour:
- Synchronisation:
  - bclk, lrclk and sdata each pass through a 2-flop synchroniser (identical delay, so alignment is preserved).
  - A bclk rising edge (brise) is detected when the synced bclk was 0 in the previous clk and is 1 now.
  - lrclk and sdata are sampled only on brise.
- Edge rule (I2S, 1-bit delay):
  - On a brise where sampled lrclk differs from the lrclk sampled at the previous brise, that bit is the previous word's LSB slot.
  - The new word's MSB is captured on the next brise.
- State machine:
  - IDLE (after reset, or while enable=0): wait for an lrclk 1->0 change at a brise, then go to ARM_L. Reception always starts on a left word.
  - ARM_L / ARM_R: on the next brise capture the MSB, set bitcnt=1, go to SHIFT_L / SHIFT_R.
  - SHIFT_L / SHIFT_R: shift sdata in MSB-first on each brise until bitcnt=WIDTH, then go to WAIT_L / WAIT_R.
  - WAIT_L / WAIT_R: ignore extra slot bits (slots wider than WIDTH are legal).
  - WAIT_L, on lrclk 0->1: store the left shadow register, go to ARM_R.
  - WAIT_R, on lrclk 1->0: go to ARM_L.
- Commit:
  - In the clk cycle after the WIDTH-th right bit is shifted in, left_out <= left shadow, right_out <= right shift register, and frame_valid=1 for exactly one clk.
  - Both outputs update together, never one alone.
  - Latency from the final right-bit brise to frame_valid is one clk (the synchroniser delay precedes this).
- Short slot:
  - An lrclk change while in SHIFT_L/SHIFT_R (fewer than WIDTH bits received) sets sync_err=1.
  - The partial word and any pending left shadow are discarded; no frame_valid for that frame.
  - The FSM then enters ARM_L if the change is 1->0, otherwise IDLE.
- Unexpected direction: an lrclk change of the wrong direction for the current state is treated the same as a short slot.
- sync_err is cleared only by reset or by enable=0.
- enable=0:
  - Takes effect the next clk. FSM goes to IDLE, shift registers and bitcnt are cleared, frame_valid=0.
  - left_out/right_out hold their values.
  - On re-enable, reception resynchronises at the next lrclk 1->0.
- Reset (asynchronous, mid-operation allowed): left_out, right_out, frame_valid, sync_err, synchronisers, shift registers and bitcnt all go to 0, and the FSM goes to IDLE immediately.
- Simultaneous events:
  - brise and an enable fall in the same clk: enable wins, no capture.
  - Commit and an enable fall in the same clk: no frame_valid.
- No arithmetic: samples pass through bit-exact, sign preserved.

Test Plan:
- Nominal, WIDTH=16, 32-bit slots, clk=16x bclk: left=0x8001, right=0x7FFF -> exactly one frame_valid pulse, left_out=0x8001, right_out=0x7FFF, sync_err=0. Pulse lands 1 clk after the right word's 16th brise, plus the synchroniser delay.
- Exact 16-bit slots, three frames (0x1234/0xABCD, 0x0000/0xFFFF, 0x7FFF/0x8000) -> three pulses with matching values, one per frame, LSB-slot handling correct.
- Start mid-frame: release reset while lrclk=1 partway through a right word -> no frame_valid until a full left+right pair following the first lrclk 1->0.
- Short slot: left word with 12 bits, then lrclk rises -> sync_err=1, no pulse for that frame. The following good frame 0x0F0F/0xF0F0 is received with sync_err still 1. enable low for 1 clk -> sync_err=0.
- Mid-word enable drop: enable=0 after 8 right bits -> no pulse, outputs hold the previous frame. Re-enable: the next complete frame after lrclk 1->0 is received correctly.
- Asynchronous reset asserted mid-shift, between clk edges -> all outputs 0 before the next clk edge. After release, the first frame is received only after an lrclk 1->0.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples BCLK/LRCLK/SDATA in the clk domain and emits
// a parallel stereo pair with a one-cycle frame strobe.
`timescale 1ns/1ps
module i2s_rx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             bclk,
  input  logic             lrclk,
  input  logic             sdata,
  output logic [WIDTH-1:0] left_out,
  output logic [WIDTH-1:0] right_out,
  output logic             frame_valid,
  output logic             sync_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM_L   = 3'd1,
    S_SHIFT_L = 3'd2,
    S_WAIT_L  = 3'd3,
    S_ARM_R   = 3'd4,
    S_SHIFT_R = 3'd5,
    S_WAIT_R  = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_err_state;
  logic [2:0]       r_bclk_sync;
  logic [1:0]       r_lr_sync;
  logic [1:0]       r_sd_sync;
  logic             r_lr_prev;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_left_shadow;
  logic [WIDTH-1:0] r_left_out;
  logic [WIDTH-1:0] r_right_out;
  logic             r_frame_valid;
  logic             r_sync_err;
  logic [CW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_lr;
  logic             w_sd;
  logic             w_brise;
  logic             w_chg;
  logic             w_rise;
  logic             w_fall;
  logic             w_last;
  logic             w_load_msb;
  logic             w_shift_en;
  logic             w_left_done;
  logic             w_right_done;
  logic             w_err;

  assign w_lr        = r_lr_sync[1];
  assign w_sd        = r_sd_sync[1];
  assign w_brise     = r_bclk_sync[1] & ~r_bclk_sync[2];
  assign w_chg       = w_brise & (w_lr ^ r_lr_prev);
  assign w_rise      = w_chg & w_lr;
  assign w_fall      = w_chg & ~w_lr;
  assign w_last      = (r_bitcnt == CW'(WIDTH - 1));
  assign w_shift_nxt = {r_shift[WIDTH-2:0], w_sd};
  // A framing error resynchronises on a falling LRCLK, otherwise waits in IDLE.
  assign w_err_state = w_fall ? S_ARM_L : S_IDLE;

  assign left_out    = r_left_out;
  assign right_out   = r_right_out;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;

  // Synchronisers, BCLK edge history and the LRCLK value of the previous bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bclk_sync <= 3'b000;
      r_lr_sync   <= 2'b00;
      r_sd_sync   <= 2'b00;
      r_lr_prev   <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[1:0], bclk};
      r_lr_sync   <= {r_lr_sync[0], lrclk};
      r_sd_sync   <= {r_sd_sync[0], sdata};
      if (w_brise) begin
        r_lr_prev <= w_lr;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else if (!enable) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes; a word whose LSB lands on the LRCLK change is complete.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_msb   = 1'b0;
    w_shift_en   = 1'b0;
    w_left_done  = 1'b0;
    w_right_done = 1'b0;
    w_err        = 1'b0;
    if (w_brise) begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            w_state_nxt = S_ARM_L;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_ARM_L, S_ARM_R: begin
          if (w_chg) begin
            w_err       = 1'b1;
            w_state_nxt = w_err_state;
          end else begin
            w_load_msb  = 1'b1;
            w_state_nxt = (r_state == S_ARM_L) ? S_SHIFT_L : S_SHIFT_R;
          end
        end
        S_SHIFT_L: begin
          if (w_rise && w_last) begin
            w_shift_en  = 1'b1;
            w_left_done = 1'b1;
            w_state_nxt = S_ARM_R;
          end else if (w_chg) begin
            w_err       = 1'b1;
            w_state_nxt = w_err_state;
          end else begin
            w_shift_en = 1'b1;
            if (w_last) begin
              w_left_done = 1'b1;
              w_state_nxt = S_WAIT_L;
            end else begin
              w_state_nxt = S_SHIFT_L;
            end
          end
        end
        S_SHIFT_R: begin
          if (w_fall && w_last) begin
            w_shift_en   = 1'b1;
            w_right_done = 1'b1;
            w_state_nxt  = S_ARM_L;
          end else if (w_chg) begin
            w_err       = 1'b1;
            w_state_nxt = w_err_state;
          end else begin
            w_shift_en = 1'b1;
            if (w_last) begin
              w_right_done = 1'b1;
              w_state_nxt  = S_WAIT_R;
            end else begin
              w_state_nxt = S_SHIFT_R;
            end
          end
        end
        S_WAIT_L: begin
          if (w_rise) begin
            w_state_nxt = S_ARM_R;
          end else if (w_chg) begin
            w_err       = 1'b1;
            w_state_nxt = w_err_state;
          end else begin
            w_state_nxt = S_WAIT_L;
          end
        end
        S_WAIT_R: begin
          if (w_fall) begin
            w_state_nxt = S_ARM_L;
          end else if (w_chg) begin
            w_err       = 1'b1;
            w_state_nxt = w_err_state;
          end else begin
            w_state_nxt = S_WAIT_R;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Shift/count datapath, left shadow, committed outputs and the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift       <= {WIDTH{1'b0}};
      r_left_shadow <= {WIDTH{1'b0}};
      r_bitcnt      <= {CW{1'b0}};
      r_left_out    <= {WIDTH{1'b0}};
      r_right_out   <= {WIDTH{1'b0}};
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else if (!enable) begin
      r_shift       <= {WIDTH{1'b0}};
      r_left_shadow <= {WIDTH{1'b0}};
      r_bitcnt      <= {CW{1'b0}};
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_frame_valid <= w_right_done;
      if (w_right_done) begin
        r_left_out  <= r_left_shadow;
        r_right_out <= w_shift_nxt;
      end
      if (w_err) begin
        r_shift  <= {WIDTH{1'b0}};
        r_bitcnt <= {CW{1'b0}};
      end else if (w_load_msb) begin
        r_shift  <= {{(WIDTH-1){1'b0}}, w_sd};
        r_bitcnt <= CW'(1);
      end else if (w_shift_en) begin
        r_shift  <= w_shift_nxt;
        r_bitcnt <= r_bitcnt + CW'(1);
      end
      if (w_left_done) begin
        r_left_shadow <= w_shift_nxt;
      end else if (w_err) begin
        r_left_shadow <= {WIDTH{1'b0}};
      end
      if (w_err) begin
        r_sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Randomised I2S stimulus with a slot-level reference model and a scoreboard
// monitor that checks every frame strobe.
`timescale 1ns/1ps
module tb_i2s_rx;
  localparam int W    = 16;
  localparam int HALF = 80;

  logic         clk = 1'b0;
  logic         reset, enable, bclk, lrclk, sdata;
  logic [W-1:0] left_out, right_out;
  logic         frame_valid, sync_err;

  i2s_rx #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata), .left_out(left_out), .right_out(right_out),
    .frame_valid(frame_valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] l; logic [W-1:0] r; } frame_t;
  frame_t exp_q[$];
  longint t_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, tracked per slot
  logic         m_prev_lr = 1'b0;
  bit           m_synced = 0, m_have_left = 0, m_err = 0, m_err_pend = 0;
  logic [W-1:0] m_left = '0, last_l = '0, last_r = '0;
  logic         r_pend = 1'b0;
  bit           r_pend_mark = 0;
  frame_t       mon_f;
  longint       mon_t, mon_p1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_err(input string name);
    check(name, {63'd0, sync_err}, {63'd0, m_err});
  endtask

  task automatic model_slot(input logic lr, input logic [W-1:0] word, input int len, output bit good);
    frame_t f;
    good = 0;
    if (m_err_pend && (lr != m_prev_lr)) m_err = 1;
    m_err_pend = 0;
    if (lr == 1'b0) begin
      if (m_prev_lr == 1'b1) m_synced = 1;
      if (m_synced) begin
        if (len >= W) begin
          m_left = word; m_have_left = 1;
        end else begin
          m_err_pend = 1; m_synced = 0; m_have_left = 0;
        end
      end
    end else begin
      if (m_synced && m_have_left) begin
        if (len >= W) begin
          f.l = m_left; f.r = word; exp_q.push_back(f);
          last_l = m_left; last_r = word; good = 1;
        end else begin
          m_err_pend = 1;
        end
      end
      m_have_left = 0;
    end
    m_prev_lr = lr;
  endtask

  task automatic model_partial(input logic lr);
    if (m_err_pend && (lr != m_prev_lr)) m_err = 1;
    m_err_pend = 0; m_synced = 0; m_have_left = 0; m_prev_lr = lr;
  endtask

  task automatic model_disable();
    m_synced = 0; m_have_left = 0; m_err = 0; m_err_pend = 0;
  endtask

  task automatic model_reset();
    model_disable();
    m_prev_lr = 1'b0; last_l = '0; last_r = '0;
  endtask

  task automatic send_bit(input logic lr, input logic d, input bit mark);
    bclk = 1'b0; lrclk = lr; sdata = d;
    #(HALF);
    bclk = 1'b1;
    if (mark) t_q.push_back(longint'($time));
    #(HALF);
  endtask

  // Data trails LRCLK by one bit: each slot's first bit carries the previous word's LSB.
  task automatic emit(input logic lr, input logic [W-1:0] word, input int len, input bit good);
    logic d;
    for (int i = 0; i < len; i++) begin
      if (i < W) d = word[W-1-i];
      else d = 1'($urandom_range(1, 0));
      send_bit(lr, r_pend, r_pend_mark);
      r_pend = d;
      r_pend_mark = good && (i == W - 1);
    end
  endtask

  task automatic push_slot(input logic lr, input logic [W-1:0] word, input int len);
    bit good;
    model_slot(lr, word, len, good);
    emit(lr, word, len, good);
  endtask

  task automatic push_partial(input logic lr, input logic [W-1:0] word, input int n);
    model_partial(lr);
    emit(lr, word, n, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_left"}, 64'(left_out), 64'd0);
    check({tag, "_right"}, 64'(right_out), 64'd0);
    check({tag, "_fv"}, {63'd0, frame_valid}, 64'd0);
    check({tag, "_err"}, {63'd0, sync_err}, 64'd0);
  endtask

  // Scoreboard monitor, sampling on the inactive clock edge
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_frame: actual L=%h R=%h, expected no frame at %0t", left_out, right_out, $time);
      end else begin
        mon_f = exp_q.pop_front();
        check("left_out", 64'(left_out), 64'(mon_f.l));
        check("right_out", 64'(right_out), 64'(mon_f.r));
        if (t_q.size() == 0) begin
          check("fv_timestamp", 64'd0, 64'd1);
        end else begin
          mon_t  = t_q.pop_front();
          mon_p1 = mon_t + ((15 - (mon_t % 10)) % 10);
          check("fv_latency", 64'($time), 64'(mon_p1 + 25));
        end
      end
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    #18;
    check_zero("reset");
    // Reset released part-way through a right word
    push_partial(1'b1, 16'h1111, 10);
    reset = 1'b1;
    model_reset();
    push_partial(1'b1, 16'h2222, 22);
    push_slot(1'b0, 16'h8001, 32);
    push_slot(1'b1, 16'h7FFF, 32);
    check_err("sync_err_nominal");
    // Exact-width slots
    push_slot(1'b0, 16'h1234, 16); push_slot(1'b1, 16'hABCD, 16);
    push_slot(1'b0, 16'h0000, 16); push_slot(1'b1, 16'hFFFF, 16);
    push_slot(1'b0, 16'h7FFF, 16); push_slot(1'b1, 16'h8000, 16);
    check_err("sync_err_exact");
    // Short left slot, then a good frame with the flag still set
    push_slot(1'b0, 16'h0ABC, 12);
    push_slot(1'b1, 16'($urandom), 32);
    push_slot(1'b0, 16'h0F0F, 32);
    push_slot(1'b1, 16'hF0F0, 32);
    check_err("sync_err_sticky");
    enable = 1'b0;
    @(posedge clk);
    #3;
    enable = 1'b1;
    model_disable();
    check("sync_err_cleared", {63'd0, sync_err}, 64'd0);
    // Enable drop after 8 right bits
    push_slot(1'b0, 16'h1357, 32);
    push_partial(1'b1, 16'h2468, 8);
    enable = 1'b0;
    #50;
    check("hold_left", 64'(left_out), 64'(last_l));
    check("hold_right", 64'(right_out), 64'(last_r));
    check("hold_err", {63'd0, sync_err}, 64'd0);
    enable = 1'b1;
    model_disable();
    push_slot(1'b0, 16'h5A5A, 32);
    push_slot(1'b1, 16'hA5A5, 32);
    check_err("sync_err_reenable");
    // Asynchronous reset in the middle of a left word
    push_partial(1'b0, 16'h3C3C, 8);
    reset = 1'b0;
    #1;
    check_zero("midreset");
    #29;
    reset = 1'b1;
    model_reset();
    push_partial(1'b0, 16'h3C3C, 24);
    push_slot(1'b1, 16'($urandom), 32);
    push_slot(1'b0, 16'hC3C3, 32);
    push_slot(1'b1, 16'h3C3C, 32);
    check_err("sync_err_postreset");
    // Random frames, slot widths and occasional short slots
    for (int k = 0; k < 12; k++) begin
      int ll, rl;
      ll = ($urandom_range(5, 0) == 0) ? int'($urandom_range(W - 1, 4)) : int'($urandom_range(32, W));
      rl = ($urandom_range(5, 0) == 0) ? int'($urandom_range(W - 1, 4)) : int'($urandom_range(32, W));
      push_slot(1'b0, 16'($urandom), ll);
      push_slot(1'b1, 16'($urandom), rl);
      check_err("sync_err_rand");
    end
    push_slot(1'b0, 16'($urandom), 32);
    #400;
    check("frames_pending", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
